// File: rtl/card_pkg.sv
// Shared types and helpers for the card shoe dealer and its hand scorer.
// Ranks are 1..13 (A..K); 0 marks an empty slot.
package card_pkg;

  localparam int NUM_RANKS      = 13;
  localparam int CARDS_PER_DECK = 52;

  typedef logic [3:0] rank_t;

  typedef enum logic [2:0] {P1, P2, P3, D1, D2, D3} slot_e;

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_e;

  // Baccarat value: pip cards count face value, tens and court cards count zero.
  function automatic logic [3:0] card_value(input rank_t r);
    return (r >= 4'd1 && r <= 4'd9) ? r : 4'd0;
  endfunction

endpackage

// File: rtl/hand_score.sv
// Combinational baccarat hand total: sum of three card values, modulo 10.
module hand_score import card_pkg::*; (
  input  rank_t       card1,
  input  rank_t       card2,
  input  rank_t       card3,
  output logic [3:0]  score
);

  logic [4:0] sum;

  always_comb begin
    sum   = 5'(card_value(card1)) + 5'(card_value(card2)) + 5'(card_value(card3));
    score = 4'(sum % 5'd10);
  end

endmodule

// File: rtl/card_shoe_dealer.sv
// Finite-shoe card dealer: serves load strobes by drawing from a free-running rank
// pointer, skipping depleted ranks, and exposes the six slots plus hand scores.
module card_shoe_dealer import card_pkg::*; #(
  parameter int DECKS = 1,
  parameter int CNT_W = 6
) (
  input  logic             slow_clock,
  input  logic             reset,
  input  logic             new_shoe,
  input  logic             new_hand,
  input  logic             load_pcard1,
  input  logic             load_pcard2,
  input  logic             load_pcard3,
  input  logic             load_dcard1,
  input  logic             load_dcard2,
  input  logic             load_dcard3,
  output logic [3:0]       pcard1,
  output logic [3:0]       pcard2,
  output logic [3:0]       pcard3,
  output logic [3:0]       dcard1,
  output logic [3:0]       dcard2,
  output logic [3:0]       dcard3,
  output logic [3:0]       pscore,
  output logic [3:0]       dscore,
  output logic [3:0]       pcard3_val,
  output logic             busy,
  output logic             card_valid,
  output logic             draw_fail,
  output logic             shoe_empty,
  output logic [CNT_W-1:0] cards_left
);

  localparam int COPIES  = 4 * DECKS;
  localparam int COUNT_W = $clog2(COPIES + 1);

  typedef logic [COUNT_W-1:0] count_t;

  state_e           state_q, state_d;
  slot_e            target_q, target_d;
  logic [3:0]       ptr_q, ptr_d;
  logic [3:0]       miss_q, miss_d;
  logic             ok_q, ok_d;
  logic [CNT_W-1:0] cards_left_q, cards_left_d;
  rank_t            slot_q [6];
  rank_t            slot_d [6];
  count_t           count_q [1:NUM_RANKS];
  count_t           count_d [1:NUM_RANKS];

  always_comb begin
    ptr_d        = (ptr_q == 4'(NUM_RANKS)) ? 4'd1 : ptr_q + 4'd1;
    state_d      = state_q;
    target_d     = target_q;
    miss_d       = miss_q;
    ok_d         = ok_q;
    cards_left_d = cards_left_q;
    slot_d       = slot_q;
    count_d      = count_q;

    if (new_shoe) begin
      state_d      = S_IDLE;
      miss_d       = 4'd0;
      ok_d         = 1'b0;
      cards_left_d = CNT_W'(CARDS_PER_DECK * DECKS);
      for (int i = 0; i < 6; i++) slot_d[i] = '0;
      for (int r = 1; r <= NUM_RANKS; r++) count_d[r] = count_t'(COPIES);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (new_hand) begin
            for (int i = 0; i < 6; i++) slot_d[i] = '0;
          end
          // Strobes arriving together resolve player-first; the losers are dropped.
          if (load_pcard1 || load_pcard2 || load_pcard3 ||
              load_dcard1 || load_dcard2 || load_dcard3) begin
            if      (load_pcard1) target_d = P1;
            else if (load_pcard2) target_d = P2;
            else if (load_pcard3) target_d = P3;
            else if (load_dcard1) target_d = D1;
            else if (load_dcard2) target_d = D2;
            else                  target_d = D3;
            miss_d  = 4'd0;
            state_d = S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (count_q[ptr_q] != '0) begin
            slot_d[target_q] = ptr_q;
            count_d[ptr_q]   = count_q[ptr_q] - count_t'(1);
            cards_left_d     = cards_left_q - CNT_W'(1);
            ok_d             = 1'b1;
            state_d          = S_DONE;
          end else if (miss_q == 4'd12) begin
            // Thirteen consecutive misses covered every rank: the shoe is empty.
            slot_d[target_q] = '0;
            ok_d             = 1'b0;
            state_d          = S_DONE;
          end else begin
            miss_d = miss_q + 4'd1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      target_q     <= P1;
      ptr_q        <= 4'd1;
      miss_q       <= 4'd0;
      ok_q         <= 1'b0;
      cards_left_q <= CNT_W'(CARDS_PER_DECK * DECKS);
      for (int i = 0; i < 6; i++) slot_q[i] <= '0;
      for (int r = 1; r <= NUM_RANKS; r++) count_q[r] <= count_t'(COPIES);
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      ptr_q        <= ptr_d;
      miss_q       <= miss_d;
      ok_q         <= ok_d;
      cards_left_q <= cards_left_d;
      slot_q       <= slot_d;
      count_q      <= count_d;
    end
  end

  assign pcard1     = slot_q[P1];
  assign pcard2     = slot_q[P2];
  assign pcard3     = slot_q[P3];
  assign dcard1     = slot_q[D1];
  assign dcard2     = slot_q[D2];
  assign dcard3     = slot_q[D3];
  assign pcard3_val = card_value(slot_q[P3]);
  assign busy       = (state_q != S_IDLE);
  assign card_valid = (state_q == S_DONE) && ok_q;
  assign draw_fail  = (state_q == S_DONE) && !ok_q;
  assign cards_left = cards_left_q;
  assign shoe_empty = (cards_left_q == '0);

  hand_score u_player_score (
    .card1 (slot_q[P1]),
    .card2 (slot_q[P2]),
    .card3 (slot_q[P3]),
    .score (pscore)
  );

  hand_score u_dealer_score (
    .card1 (slot_q[D1]),
    .card2 (slot_q[D2]),
    .card3 (slot_q[D3]),
    .score (dscore)
  );

endmodule
